// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD and FCS, checks CRC-32 and frame length,
// and emits a flagged byte stream with a fixed 7-cycle input-to-output latency.
module gmii_rx_deframer #(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1522,
   parameter int CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [7:0]       gmii_rxd,
   input  logic             gmii_rx_dv,
   input  logic             gmii_rx_er,
   input  logic             stats_clear,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             rx_sof,
   output logic             rx_eof,
   output logic             rx_err,
   output logic [CNT_W-1:0] frames_ok,
   output logic [CNT_W-1:0] frames_bad,
   output logic [CNT_W-1:0] align_err
);

   localparam logic [15:0] MIN_L       = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_L       = 16'(MAX_FRAME);
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [1:0] {IDLE, PREAMBLE, BODY, DROP} state_t;
   state_t state, state_nxt;

   logic [7:0]  rxd_p0;
   logic        dv_p0, er_p0;
   logic [7:0]  dly_data_p1 [5];
   logic [4:0]  dly_vld_p1;
   logic [31:0] crc;
   logic [15:0] len, len_inc;
   logic        er_seen, giant, sof_pend;
   logic        push, emit, frame_err, start, leave;
   logic        o_valid, o_sof, o_eof, o_err;
   logic [7:0]  o_data;
   logic        inc_ok, inc_bad, inc_align;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic inc, input logic clr);
      if (clr)
         return '0;
      else if (inc && (cur != {CNT_W{1'b1}}))
         return cur + 1'b1;
      else
         return cur;
   endfunction

   assign push      = (state == BODY) && dv_p0;
   // A byte is known to be payload only once four more bytes of the same frame follow it.
   assign emit      = (state == BODY) && (&dly_vld_p1);
   assign len_inc   = (push && (len != 16'hFFFF)) ? len + 16'd1 : len;
   assign frame_err = (crc != CRC_RESIDUE) || er_seen || (len < MIN_L) || giant;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      leave     = 1'b0;
      o_valid   = 1'b0;
      o_sof     = 1'b0;
      o_eof     = 1'b0;
      o_err     = 1'b0;
      o_data    = dly_data_p1[4];
      inc_ok    = 1'b0;
      inc_bad   = 1'b0;
      inc_align = 1'b0;
      case (state)
         IDLE, PREAMBLE: begin
            if (!dv_p0)
               state_nxt = IDLE;
            else if (rxd_p0 == 8'h55)
               state_nxt = PREAMBLE;
            else if (rxd_p0 == 8'hD5) begin
               state_nxt = BODY;
               start     = 1'b1;
            end else begin
               state_nxt = DROP;
               inc_align = 1'b1;
            end
         end
         BODY: begin
            if (!dv_p0) begin
               state_nxt = IDLE;
               leave     = 1'b1;
               o_valid   = 1'b1;
               o_eof     = 1'b1;
               if (emit) begin
                  o_sof = sof_pend;
                  o_err = frame_err;
               end else begin
                  // Fewer than five bytes: nothing was emitted, so one marker beat stands in.
                  o_sof  = 1'b1;
                  o_err  = 1'b1;
                  o_data = 8'h00;
               end
               inc_ok  = !o_err;
               inc_bad = o_err;
            end else if (emit) begin
               o_valid = 1'b1;
               o_sof   = sof_pend;
               if (giant) begin
                  o_eof     = 1'b1;
                  o_err     = 1'b1;
                  inc_bad   = 1'b1;
                  leave     = 1'b1;
                  state_nxt = DROP;
               end
            end
         end
         DROP: begin
            if (!dv_p0)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rxd_p0     <= 8'h00;
         dv_p0      <= 1'b0;
         er_p0      <= 1'b0;
         state      <= IDLE;
         dly_vld_p1 <= 5'd0;
         crc        <= CRC_INIT;
         len        <= 16'd0;
         er_seen    <= 1'b0;
         giant      <= 1'b0;
         sof_pend   <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_sof     <= 1'b0;
         rx_eof     <= 1'b0;
         rx_err     <= 1'b0;
         frames_ok  <= '0;
         frames_bad <= '0;
         align_err  <= '0;
      end else begin
         // p0: GMII capture
         rxd_p0     <= gmii_rxd;
         dv_p0      <= gmii_rx_dv;
         er_p0      <= gmii_rx_er;
         state      <= state_nxt;
         // p1: delay line valid bits, frame accumulators
         dly_vld_p1 <= leave ? 5'd0 : {dly_vld_p1[3:0], push};
         if (start) begin
            crc      <= CRC_INIT;
            len      <= 16'd0;
            er_seen  <= 1'b0;
            giant    <= 1'b0;
            sof_pend <= 1'b1;
         end else begin
            if (push)
               crc <= crc_byte(crc, rxd_p0);
            len     <= len_inc;
            er_seen <= er_seen | (push & er_p0);
            giant   <= giant | (push && (len_inc > MAX_L));
            if (o_valid)
               sof_pend <= 1'b0;
         end
         // output stage
         rx_valid   <= o_valid;
         rx_sof     <= o_sof;
         rx_eof     <= o_eof;
         rx_err     <= o_err;
         rx_data    <= o_valid ? o_data : 8'h00;
         frames_ok  <= cnt_next(frames_ok, inc_ok, stats_clear);
         frames_bad <= cnt_next(frames_bad, inc_bad, stats_clear);
         align_err  <= cnt_next(align_err, inc_align, stats_clear);
      end
   end

   always_ff @(posedge CLK) begin
      dly_data_p1[0] <= rxd_p0;
      for (int i = 1; i < 5; i++)
         dly_data_p1[i] <= dly_data_p1[i-1];
   end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: table of frames plus hand-written sequences for
// giant, alignment, back-to-back, mid-frame reset and counter-clear corner cases.
module tb_gmii_rx_deframer;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [7:0]  gmii_rxd = 8'h00;
   logic        gmii_rx_dv = 1'b0;
   logic        gmii_rx_er = 1'b0;
   logic        stats_clear = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof, rx_err;
   logic [15:0] frames_ok, frames_bad, align_err;

   gmii_rx_deframer #(.MIN_FRAME(64), .MAX_FRAME(1522), .CNT_W(16)) dut (
      .CLK(CLK), .RST_N(RST_N), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
      .gmii_rx_er(gmii_rx_er), .stats_clear(stats_clear), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_err(rx_err),
      .frames_ok(frames_ok), .frames_bad(frames_bad), .align_err(align_err)
   );

   always #4 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
      logic       err;
      int         cyc;
   } beat_t;
   beat_t q[$];

   always @(negedge CLK)
      if (rx_valid === 1'b1)
         q.push_back('{d: rx_data, sof: rx_sof, eof: rx_eof, err: rx_err, cyc: cyc});

   typedef struct {
      int pre;
      int len;
      bit flip;
      bit er;
      int beats;
      bit err;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int exp_ok = 0;
   int exp_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pay(input int seed, input int i);
      return 8'(seed * 37 + i * 11 + 5);
   endfunction

   function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         fb = c[0] ^ b[i];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB8_8320;
      end
      return c;
   endfunction

   task automatic drv(input logic dv, input logic er, input logic [7:0] d, input logic clr);
      @(posedge CLK);
      #1;
      gmii_rx_dv  = dv;
      gmii_rx_er  = er;
      gmii_rxd    = d;
      stats_clear = clr;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // n = bytes after SFD including FCS; frames shorter than 4 bytes carry no FCS
   task automatic send_frame(input int pre, input int n, input int seed, input bit flip,
                             input bit er, output int t0);
      logic [31:0] c;
      logic [7:0]  b;
      int          np;
      np = (n >= 4) ? n - 4 : n;
      c  = 32'hFFFF_FFFF;
      for (int i = 0; i < np; i++) c = crc_upd(c, pay(seed, i));
      c = ~c;
      for (int i = 0; i < pre; i++) drv(1'b1, 1'b0, 8'h55, 1'b0);
      drv(1'b1, 1'b0, 8'hD5, 1'b0);
      t0 = 0;
      for (int i = 0; i < n; i++) begin
         if (i < np) begin
            b = pay(seed, i);
            if (flip && i == 10) b = b ^ 8'h01;
         end else begin
            b = c[8*(i-np) +: 8];
         end
         drv(1'b1, er && (i == 20), b, 1'b0);
         if (i == 0) t0 = cyc;
      end
   endtask

   task automatic check_frame(input string tag, input int seed, input bit flip, input int n,
                              input int beats, input bit err, input int t0);
      int         sofs, eofs, mism;
      logic [7:0] e;
      check({tag, "_beats"}, q.size(), beats);
      if (q.size() > 0) begin
         sofs = 0; eofs = 0; mism = 0;
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].sof) sofs++;
            if (q[i].eof) eofs++;
            e = (n < 5) ? 8'h00 : (pay(seed, i) ^ ((flip && i == 10) ? 8'h01 : 8'h00));
            if (q[i].d !== e) mism++;
         end
         check({tag, "_sof_count"}, sofs, 1);
         check({tag, "_first_sof"}, q[0].sof, 1);
         check({tag, "_eof_count"}, eofs, 1);
         check({tag, "_last_eof"}, q[q.size()-1].eof, 1);
         check({tag, "_last_err"}, q[q.size()-1].err, err);
         check({tag, "_data_errors"}, mism, 0);
         if (n >= 5) check({tag, "_latency"}, q[0].cyc - t0, 7);
      end
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_frames_ok"}, frames_ok, exp_ok);
      check({tag, "_frames_bad"}, frames_bad, exp_bad);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[10];
      int   t0, ta, tb;
      int   mism;

      vecs[0] = '{7, 64,   1'b0, 1'b0, 60,   1'b0};  // minimum legal frame
      vecs[1] = '{7, 64,   1'b1, 1'b0, 60,   1'b1};  // payload bit flipped
      vecs[2] = '{7, 40,   1'b0, 1'b0, 36,   1'b1};  // runt, valid FCS
      vecs[3] = '{7, 3,    1'b0, 1'b0, 1,    1'b1};  // short marker beat
      vecs[4] = '{7, 5,    1'b0, 1'b0, 1,    1'b1};  // shortest frame with one real byte
      vecs[5] = '{7, 64,   1'b0, 1'b1, 60,   1'b1};  // rx_er inside body
      vecs[6] = '{0, 64,   1'b0, 1'b0, 60,   1'b0};  // SFD straight from idle
      vecs[7] = '{7, 63,   1'b0, 1'b0, 59,   1'b1};  // one byte under minimum
      vecs[8] = '{2, 1522, 1'b0, 1'b0, 1518, 1'b0};  // maximum legal frame
      vecs[9] = '{7, 0,    1'b0, 1'b0, 1,    1'b1};  // SFD then nothing

      repeat (3) @(posedge CLK);
      #1;
      check("reset_valid", rx_valid, 0);
      check("reset_sof", rx_sof, 0);
      check("reset_eof", rx_eof, 0);
      check("reset_err", rx_err, 0);
      check("reset_data", rx_data, 0);
      check("reset_frames_ok", frames_ok, 0);
      check("reset_frames_bad", frames_bad, 0);
      check("reset_align_err", align_err, 0);
      #1;
      RST_N = 1'b1;
      idle(3);

      foreach (vecs[k]) begin
         q.delete();
         send_frame(vecs[k].pre, vecs[k].len, k + 1, vecs[k].flip, vecs[k].er, t0);
         idle(14);
         check_frame($sformatf("vec%0d", k), k + 1, vecs[k].flip, vecs[k].len,
                     vecs[k].beats, vecs[k].err, t0);
         if (vecs[k].err) exp_bad++; else exp_ok++;
         check_counters($sformatf("vec%0d", k));
      end
      check("table_align_err", align_err, 0);

      // Giant: length reaches 1523, frame cut there and the rest dropped
      q.delete();
      send_frame(7, 1600, 40, 1'b0, 1'b0, t0);
      idle(14);
      check_frame("giant", 40, 1'b0, 1600, 1519, 1'b1, t0);
      exp_bad++;
      check_counters("giant");

      // rx_er without dv must not disturb the following frame
      q.delete();
      repeat (3) drv(1'b0, 1'b1, 8'hD5, 1'b0);
      send_frame(7, 64, 41, 1'b0, 1'b0, t0);
      idle(14);
      check_frame("false_carrier", 41, 1'b0, 64, 60, 1'b0, t0);
      exp_ok++;
      check_counters("false_carrier");

      // Preamble broken by 0x13
      q.delete();
      drv(1'b1, 1'b0, 8'h55, 1'b0);
      drv(1'b1, 1'b0, 8'h55, 1'b0);
      drv(1'b1, 1'b0, 8'h13, 1'b0);
      repeat (4) drv(1'b1, 1'b0, 8'h20, 1'b0);
      idle(14);
      check("align_beats", q.size(), 0);
      check("align_count", align_err, 1);
      check_counters("align");

      // Two frames with a single idle cycle between them
      q.delete();
      send_frame(7, 64, 50, 1'b0, 1'b0, ta);
      idle(1);
      send_frame(7, 64, 51, 1'b0, 1'b0, tb);
      idle(14);
      check("b2b_beats", q.size(), 120);
      if (q.size() == 120) begin
         mism = 0;
         for (int i = 0; i < 120; i++) begin
            if (q[i].d !== ((i < 60) ? pay(50, i) : pay(51, i - 60))) mism++;
            if (q[i].sof !== ((i == 0) || (i == 60))) mism++;
            if (q[i].eof !== ((i == 59) || (i == 119))) mism++;
            if ((i == 59 || i == 119) && q[i].err !== 1'b0) mism++;
         end
         check("b2b_beat_errors", mism, 0);
         check("b2b_latency_a", q[0].cyc - ta, 7);
         check("b2b_latency_b", q[60].cyc - tb, 7);
      end
      exp_ok += 2;
      check_counters("b2b");

      // Reset held for three cycles in the middle of a payload
      repeat (7) drv(1'b1, 1'b0, 8'h55, 1'b0);
      drv(1'b1, 1'b0, 8'hD5, 1'b0);
      repeat (20) drv(1'b1, 1'b0, 8'h3C, 1'b0);
      check("pre_reset_valid", rx_valid, 1);
      #2;
      RST_N = 1'b0;
      #1;
      q.delete();
      check("rst_async_valid", rx_valid, 0);
      check("rst_async_data", rx_data, 0);
      check("rst_async_frames_ok", frames_ok, 0);
      repeat (3) drv(1'b1, 1'b0, 8'h3C, 1'b0);
      #2;
      RST_N = 1'b1;
      repeat (40) drv(1'b1, 1'b0, 8'h3C, 1'b0);
      idle(14);
      check("rst_tail_beats", q.size(), 0);
      exp_ok = 0;
      exp_bad = 0;
      check_counters("rst_tail");

      q.delete();
      send_frame(7, 64, 60, 1'b0, 1'b0, t0);
      idle(14);
      check_frame("post_reset", 60, 1'b0, 64, 60, 1'b0, t0);
      exp_ok++;
      check_counters("post_reset");

      // stats_clear in the very cycle frames_ok would increment
      q.delete();
      send_frame(7, 64, 61, 1'b0, 1'b0, t0);
      drv(1'b0, 1'b0, 8'h00, 1'b0);
      drv(1'b0, 1'b0, 8'h00, 1'b1);
      drv(1'b0, 1'b0, 8'h00, 1'b0);
      idle(12);
      check_frame("clear", 61, 1'b0, 64, 60, 1'b0, t0);
      exp_ok = 0;
      exp_bad = 0;
      check_counters("clear");
      check("clear_align_err", align_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
